dmem_mp: RTL

- Parametrised successor to the single-write, single-read data SRAM model.
- Single clock, with one byte-masked write port and NUM_RD independent read ports.
- Adds a hardware zero-fill state machine after reset, selectable read latency (1 or 2), and same-cycle write-to-read collision handling with defined write-first or read-first semantics.
- Sits between the LSU/commit path and the data array of the OoO core; extra read ports serve parallel load pipes.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/dmem_rd_port.sv | 78 +++++++
 rtl/dmem_mp.sv | 97 +++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the multi-port data memory
package dmem_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_rd_port.sv
// rtl/dmem_rd_port.sv - one read port: array read, write collision merge, latency pipeline
module dmem_rd_port
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   mem_i [1 << ADDR_WIDTH],
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH/8-1:0] wr_mask_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    output logic                    rd_valid_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam int NUM_WMASKS = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] rd_word_d;
    logic                  valid1_q;
    logic [DATA_WIDTH-1:0] data1_q;

    // The array is sampled before this edge's write lands, so read-first needs no merge.
    always_comb begin
        rd_word_d = mem_i[rd_addr_i];
        if (WRITE_FIRST != 0 && wr_en_i && (wr_addr_i == rd_addr_i)) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wr_mask_i[i]) begin
                    rd_word_d[i*BYTE_W +: BYTE_W] = wr_data_i[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            data1_q  <= '0;
        end else begin
            valid1_q <= rd_en_i;
            if (rd_en_i) begin
                data1_q <= rd_word_d;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  valid2_q;
            logic [DATA_WIDTH-1:0] data2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid2_q <= 1'b0;
                    data2_q  <= '0;
                end else begin
                    valid2_q <= valid1_q;
                    if (valid1_q) begin
                        data2_q <= data1_q;
                    end
                end
            end

            assign rd_valid_o = valid2_q;
            assign rd_data_o  = data2_q;
        end else begin : g_lat1
            assign rd_valid_o = valid1_q;
            assign rd_data_o  = data1_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_mp.sv
// rtl/dmem_mp.sv - multi-read-port data SRAM with post-reset zero fill
module dmem_mp
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int NUM_RD       = 2,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         init_busy,
    input  logic                         w_en,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [DATA_WIDTH/8-1:0]      w_mask,
    input  logic [DATA_WIDTH-1:0]        w_data,
    input  logic [NUM_RD-1:0]            r_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
    output logic [NUM_RD-1:0]            r_valid,
    output logic [NUM_RD*DATA_WIDTH-1:0] r_data
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    dmem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready;
    logic                  wr_act;

    assign ready     = (state_q == READY);
    assign init_busy = ~ready;
    assign wr_act    = ready & w_en;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = READY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array has no reset of its own; CLEAR sweeps it once rst is released.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                mem[clr_cnt_q] <= '0;
            end else if (w_en) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (w_mask[i]) begin
                        mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            dmem_rd_port #(
                .DATA_WIDTH  (DATA_WIDTH),
                .ADDR_WIDTH  (ADDR_WIDTH),
                .READ_LATENCY(READ_LATENCY),
                .WRITE_FIRST (WRITE_FIRST)
            ) u_rd_port (
                .clk       (clk),
                .rst       (rst),
                .mem_i     (mem),
                .rd_en_i   (r_en[p] & ready),
                .rd_addr_i (r_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
                .wr_en_i   (wr_act),
                .wr_addr_i (w_addr),
                .wr_mask_i (w_mask),
                .wr_data_i (w_data),
                .rd_valid_o(r_valid[p]),
                .rd_data_o (r_data[p*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

endmodule
